neuron_dot_fetch: RTL

Read-side sequencer and multiply-accumulate engine for one neuron of the ANN layer. On a start pulse it sweeps addresses 0..DEPTH-1 into a negedge-clocked weight BRAM and a matching activation BRAM, multiplies each signed Q8.8 weight/activation pair, and accumulates the products. When the sweep ends it produces one saturated Q8.8 dot-product result with a done pulse. One instance sits between each weight BRAM pair and the activation stage.

---
 rtl/neuron_dot_fetch_if.sv | 29 ++
 rtl/neuron_dot_fetch.sv | 122 ++++++++++++
 2 files changed

// File: rtl/neuron_dot_fetch_if.sv
// Bus between one neuron's dot-product sequencer and its weight/activation BRAM
// pair, plus the start/done handshake toward the activation stage.
interface neuron_dot_fetch_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              START;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] RESULT;
  logic [ADDR_W-1:0] ADDR;
  logic              EN;
  logic              WE;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] W_DO;
  logic [DATA_W-1:0] X_DO;

  // master: the sequencer, which drives the BRAM address and reports results
  modport master (
    input  START, W_DO, X_DO,
    output ADDR, EN, WE, DI, BUSY, DONE, RESULT
  );

  // slave: BRAM pair plus the requester
  modport slave (
    output START, W_DO, X_DO,
    input  ADDR, EN, WE, DI, BUSY, DONE, RESULT
  );
endinterface

// File: rtl/neuron_dot_fetch.sv
// One-neuron dot product: sweeps both BRAMs, accumulates signed Q8.8 products
// at full precision, then emits a saturated Q8.8 result with a DONE pulse.
module neuron_dot_fetch #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic              CLK,
  input  logic              RST_N,
  neuron_dot_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     en_q, en_d;
  logic                     done_q, done_d;
  logic signed [DATA_W-1:0] result_q, result_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic                       rd_valid;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [DATA_W-1:0]   sat_val;

  // Read data at a posedge belongs to the address launched one cycle earlier,
  // so every posedge spent in FETCH retires exactly one word (P1..P(DEPTH)).
  assign rd_valid = (state_q == FETCH);
  assign prod     = $signed(bus.W_DO) * $signed(bus.X_DO);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_comb begin
    shifted = acc_q >>> FRAC;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = shifted[DATA_W-1:0];
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = FETCH;
      FETCH:   if (addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath
  always_comb begin
    addr_d   = addr_q;
    en_d     = en_q;
    done_d   = 1'b0;
    result_d = result_q;
    acc_d    = acc_q;
    if (rd_valid) acc_d = acc_q + prod_ext;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          addr_d = '0;
          en_d   = 1'b1;
          acc_d  = '0;
        end
      end
      FETCH: begin
        if (addr_q == LAST_ADDR) begin
          en_d   = 1'b0;
          addr_d = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        result_d = sat_val;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q   <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      en_q     <= en_d;
      done_q   <= done_d;
      result_q <= result_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.ADDR   = addr_q;
  assign bus.EN     = en_q;
  assign bus.WE     = 1'b0;
  assign bus.DI     = '0;
  assign bus.BUSY   = (state_q != IDLE);
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;

endmodule
